booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth signed multiplier controller: an FSM plus a shift register that time-shares one (N+1)-bit add/subtract path across N iterations.
- Sits beside the combinational adders in the Booth arithmetic group.
- Upstream logic issues a start pulse with two signed operands, then receives a 2N-bit signed product and a one-cycle done pulse.

Parameters:
- N, 5, operand width in bits. Legal range N >= 2. Product width is 2N; the internal add path is N+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- start  input  1  request; sampled only while idle.
- multiplicand  input  N  signed operand M; captured on the accepted start edge.
- multiplier  input  N  signed operand Q; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- product  output  2N  signed result; held until the next completion.

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE. Internal A, Q, Q_1, M and count are all 0.
- Reset mid-operation: the operation is aborted immediately, with no done pulse and product=0. It does not resume after reset deasserts.
- Internal registers:
  - A: N+1 bits, signed accumulator.
  - Q: N bits.
  - Q_1: 1 bit.
  - M: N+1 bits, sign-extended multiplicand.
  - count: ceil(log2(N))+1 bits.
- FSM states: IDLE, CALC, SHIFT.
- IDLE:
  - If start=1: A<=0, Q<=multiplier, Q_1<=0, M<=sext(multiplicand), count<=0, busy<=1, go to CALC.
  - done is cleared on any IDLE edge that is not a completion.
- CALC, driven by {Q[0],Q_1}:
  - 10: A<=A-M.
  - 01: A<=A+M.
  - 00 or 11: A unchanged.
  - Always go to SHIFT.
- SHIFT:
  - Arithmetic right shift of {A,Q,Q_1} by one; A's MSB is replicated. count<=count+1.
  - If count==N-1 (the last iteration): product<= low 2N bits of the shifted {A,Q}, done<=1, busy<=0, go to IDLE.
  - Otherwise go to CALC.
- Add/subtract wraps modulo 2^(N+1). The extra bit makes M=-2^(N-1) exact, so no overflow is possible and there is no overflow flag.
- Latency: done is high in the cycle following the 2N-th rising edge after the edge that accepted start (10 edges for N=5). Throughput is one result per 2N+1 edges when restarted in the done cycle.
- busy is 1 from the edge after acceptance through the final SHIFT edge. busy and done are never both 1.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the done cycle (state=IDLE) is accepted. done falls on that edge and the new operation begins.
- Operand inputs are don't-care except on the accepting edge.
- product is stable between completions and updates only on the completing edge.

Optional Feature:
- Macro: BOOTH_SKIP_EN.
- Defined:
  - In CALC with {Q[0],Q_1} = 00 or 11, the shift and count update happen in the same cycle and SHIFT is bypassed.
  - The completion rules of SHIFT apply on that edge when count==N-1.
  - Latency varies from N edges (no add/sub iterations) to 2N edges (every iteration adds or subtracts).
- Undefined: fixed 2N-edge latency exactly as above. The skip path is not synthesized.

Test Plan:
- (N=5 for all.) Reset, then start with M=3, Q=-4 -> done exactly 10 edges after acceptance; product=10'h3F4 (-12).
- M=-16, Q=-16 -> product=10'h100 (256). M=15, Q=-16 -> product=10'h310 (-240). Covers most-negative operand handling.
- M=7, Q=0 -> product=0, with 10-edge latency (macro off). With BOOTH_SKIP_EN: done after 5 edges.
- Start with M=5, Q=6; pulse start with M=1, Q=1 on edge 3 -> second start ignored; product=30; busy stays high until completion.
- Assert rst on edge 4 of an M=9, Q=9 operation -> busy=0, done=0, product=0 immediately. No done pulse follows; the next start with M=-1, Q=-1 gives product=1.
- Back-to-back: start held high through the done cycle with M=2, Q=3 and then M=-2, Q=3 -> products 6 then 10'h3FA (-6); done pulses exactly 11 edges apart.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Start/operand/result bundle between an issuing block and booth_mult_seq.
// master drives the request and operands; slave (the multiplier) returns the status and product.
interface booth_mult_seq_if #(
    parameter int N = 5
);
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: one (N+1)-bit add/sub path reused over N iterations.
// Define BOOTH_SKIP_EN to fold the shift into CALC when no add/sub is needed (variable latency).
module booth_mult_seq #(
    parameter int N = 5
) (
    input  logic            clk,
    input  logic            rst,
    booth_mult_seq_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT} state_t;

    state_t         state, state_next;
    logic [N:0]     a, a_next;
    logic [N-1:0]   q, q_next;
    logic           q_1, q_1_next;
    logic [N:0]     m, m_next;
    logic [CW-1:0]  count, count_next;
    logic           busy, busy_next;
    logic           done, done_next;
    logic [2*N-1:0] product, product_next;

    logic [N:0]     addsub;
    logic [N:0]     sh_a;
    logic [N-1:0]   sh_q;
    logic           do_shift;
    logic           last;

    // Booth recoding of {Q[0],Q_1}: 10 subtracts M, 01 adds M, otherwise A passes through.
    always_comb begin
        case ({q[0], q_1})
            2'b10:   addsub = a - m;
            2'b01:   addsub = a + m;
            default: addsub = a;
        endcase
    end

    // Arithmetic right shift of {A,Q,Q_1}; the bit leaving Q becomes the new Q_1.
    assign sh_a = {a[N], a[N:1]};
    assign sh_q = {a[0], q[N-1:1]};
    assign last = (count == CW'(N - 1));

    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        a_next       = a;
        q_next       = q;
        q_1_next     = q_1;
        m_next       = m;
        count_next   = count;
        busy_next    = busy;
        done_next    = 1'b0;
        product_next = product;
        do_shift     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_next     = '0;
                    q_next     = bus.multiplier;
                    q_1_next   = 1'b0;
                    m_next     = {bus.multiplicand[N-1], bus.multiplicand};
                    count_next = '0;
                    busy_next  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                a_next     = addsub;
                state_next = SHIFT;
`ifdef BOOTH_SKIP_EN
                if (q[0] == q_1) do_shift = 1'b1;
`endif
            end
            SHIFT: do_shift = 1'b1;
            default: state_next = IDLE;
        endcase

        if (do_shift) begin
            a_next     = sh_a;
            q_next     = sh_q;
            q_1_next   = q[0];
            count_next = count + CW'(1);
            if (last) begin
                product_next = {sh_a[N-1:0], sh_q};
                done_next    = 1'b1;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end else begin
                state_next = CALC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            a       <= a_next;
            q       <= q_next;
            q_1     <= q_1_next;
            m       <= m_next;
            count   <= count_next;
            busy    <= busy_next;
            done    <= done_next;
            product <= product_next;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases plus random operands,
// compared against integer multiplication and a Booth-recoding latency model.
module tb_booth_mult_seq;
    localparam int N = 5;
    localparam int P = 2 * N;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    booth_mult_seq_if #(.N(N)) bus ();

    booth_mult_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input logic [N-1:0] v);
        return v[N-1] ? int'(v) - (1 << N) : int'(v);
    endfunction

    function automatic logic [P-1:0] exp_prod(input logic [N-1:0] mv, input logic [N-1:0] qv);
        int p;
        p = sx(mv) * sx(qv);
        return p[P-1:0];
    endfunction

    // Every Booth digit costs two edges; with skipping, zero digits cost one.
    function automatic int exp_lat(input logic [N-1:0] qv);
        int nz;
        int prev;
        int b;
        nz   = 0;
        prev = 0;
        for (int i = 0; i < N; i++) begin
            b = int'(qv[i]);
            if (b != prev) nz++;
            prev = b;
        end
`ifdef BOOTH_SKIP_EN
        return N + nz;
`else
        return 2 * N;
`endif
    endfunction

    // Waits up to 60 edges for done; returns edge count (60 on timeout).
    task automatic wait_done(inout int edges);
        bit seen;
        seen = 1'b0;
        while (edges < 60 && !seen) begin
            tick();
            edges++;
            if (bus.done) seen = 1'b1;
            if (bus.done && bus.busy) check("busy_done_overlap", 1, 0);
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] mv, input logic [N-1:0] qv);
        int edges;
        bus.start        = 1'b1;
        bus.multiplicand = mv;
        bus.multiplier   = qv;
        tick();
        bus.start        = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
        check({tag, "_busy_after_accept"}, bus.busy, 1);
        edges = 0;
        wait_done(edges);
        check({tag, "_latency"}, edges, exp_lat(qv));
        check({tag, "_product"}, bus.product, exp_prod(mv, qv));
        check({tag, "_busy_at_done"}, bus.busy, 0);
    endtask

    initial begin
        int edges;
        int done_cnt;
        logic [N-1:0] mv, qv;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        tick();
        tick();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        rst = 1'b0;
        tick();

        run_op("m3_qm4", 5'd3, 5'h1C);
        check("m3_qm4_value", bus.product, 10'h3F4);
        tick();
        check("done_one_cycle", bus.done, 0);
        check("product_held", bus.product, 10'h3F4);

        run_op("m16_q16", 5'h10, 5'h10);
        check("m16_q16_value", bus.product, 10'h100);
        run_op("m15_q16", 5'd15, 5'h10);
        check("m15_q16_value", bus.product, 10'h310);
        run_op("m7_q0", 5'd7, 5'd0);
        check("m7_q0_value", bus.product, 0);

        // Second start on edge 3 of a busy operation must be ignored.
        bus.start        = 1'b1;
        bus.multiplicand = 5'd5;
        bus.multiplier   = 5'd6;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start        = 1'b1;
        bus.multiplicand = 5'd1;
        bus.multiplier   = 5'd1;
        tick();
        bus.start = 1'b0;
        check("ignored_start_busy", bus.busy, 1);
        edges = 3;
        wait_done(edges);
        check("ignored_start_latency", edges, exp_lat(5'd6));
        check("ignored_start_product", bus.product, 10'd30);

        // Reset on edge 4 aborts the operation immediately.
        bus.start        = 1'b1;
        bus.multiplicand = 5'd9;
        bus.multiplier   = 5'd9;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        tick();
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_busy", bus.busy, 0);
        run_op("m1_q1", 5'h1F, 5'h1F);
        check("m1_q1_value", bus.product, 10'd1);

        // Back-to-back: start held through the done cycle.
        bus.start        = 1'b1;
        bus.multiplicand = 5'd2;
        bus.multiplier   = 5'd3;
        tick();
        edges = 0;
        wait_done(edges);
        check("b2b_first_latency", edges, exp_lat(5'd3));
        check("b2b_first_product", bus.product, 10'd6);
        bus.multiplicand = 5'h1E;
        bus.multiplier   = 5'd3;
        tick();
        bus.start = 1'b0;
        check("b2b_done_falls", bus.done, 0);
        check("b2b_busy_restart", bus.busy, 1);
        edges = 1;
        wait_done(edges);
        check("b2b_done_spacing", edges, 1 + exp_lat(5'd3));
        check("b2b_second_product", bus.product, 10'h3FA);

        for (int k = 0; k < 20; k++) begin
            mv = N'($urandom);
            qv = N'($urandom);
            run_op("random", mv, qv);
            tick();
            check("random_done_low", bus.done, 0);
            check("random_product_held", bus.product, exp_prod(mv, qv));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
